// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern, hex glyph table
// and scan-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a} glyphs for 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register-file side to display-pin side bundle for seg7_scan_ctrl.
// Optional brightness_i member exists only when SEG7_SCAN_DIM_EN is defined.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]              brightness_i;
`endif
  logic [NUM_DIGITS-1:0]   an_o;
  logic [7:0]              seg_o;
  logic                    frame_tick_o;

`ifdef SEG7_SCAN_DIM_EN
  modport master (
    output digits_i, dp_i, blank_i, brightness_i,
    input  an_o, seg_o, frame_tick_o
  );
  modport slave (
    input  digits_i, dp_i, blank_i, brightness_i,
    output an_o, seg_o, frame_tick_o
  );
`else
  modport master (
    output digits_i, dp_i, blank_i,
    input  an_o, seg_o, frame_tick_o
  );
  modport slave (
    input  digits_i, dp_i, blank_i,
    output an_o, seg_o, frame_tick_o
  );
`endif

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment driver with guard gap and frame-synchronous shadowing.
// Define SEG7_SCAN_DIM_EN to add the brightness_i PWM dimming input.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 100000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};

  function automatic logic [NUM_DIGITS-1:0] an_drive(input logic [NUM_DIGITS-1:0] v);
    return (AN_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic [7:0] seg_drive(input logic [7:0] v);
    return (SEG_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] sh_digits_p0;
  logic [NUM_DIGITS-1:0]   sh_dp_p0;
  logic [NUM_DIGITS-1:0]   sh_blank_p0;

  logic [NUM_DIGITS-1:0]   an_p1;
  logic [7:0]              seg_p1;
  logic                    tick_p1;

  logic                    term;
  logic                    last;
  logic                    frame_end;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic [4*NUM_DIGITS-1:0] digits_nxt;
  logic [NUM_DIGITS-1:0]   dp_nxt;
  logic [NUM_DIGITS-1:0]   blank_nxt;
  logic [3:0]              nib_nxt;
  logic [6:0]              hex_seg;
  logic                    anode_en;
  logic [NUM_DIGITS-1:0]   an_ah;
  logic [7:0]              seg_ah;

`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]              dim_cnt_p0;
  logic [3:0]              dim_nxt;
  assign dim_nxt  = dim_cnt_p0 + 4'd1;
  assign anode_en = (dim_nxt <= bus.brightness_i);
`else
  assign anode_en = 1'b1;
`endif

  // Next-state view: output registers are computed from the state they will sit beside
  always_comb begin
    term      = (cnt_p0 == CNT_LAST);
    last      = (idx_p0 == IDX_LAST);
    frame_end = term && last;
    cnt_nxt   = term ? '0 : cnt_p0 + 1'b1;
    idx_nxt   = idx_p0;
    if (term) begin
      idx_nxt = last ? '0 : idx_p0 + 1'b1;
    end
    digits_nxt = frame_end ? bus.digits_i : sh_digits_p0;
    dp_nxt     = frame_end ? bus.dp_i     : sh_dp_p0;
    blank_nxt  = frame_end ? bus.blank_i  : sh_blank_p0;
    nib_nxt    = digits_nxt[{idx_nxt, 2'b00} +: 4];
  end

  seg7_hex_decode u_dec (
    .nibble (nib_nxt),
    .seg    (hex_seg)
  );

  always_comb begin
    an_ah  = '0;
    seg_ah = {1'b0, SEG_BLANK};
    if (cnt_nxt != '0) begin
      an_ah[idx_nxt] = anode_en;
      if (!blank_nxt[idx_nxt]) begin
        seg_ah = {dp_nxt[idx_nxt], hex_seg};
      end
    end
  end

  // Stage p0: prescaler, scan index, shadows; stage p1: polarity-adjusted pin registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0       <= '0;
      idx_p0       <= '0;
      sh_digits_p0 <= '0;
      sh_dp_p0     <= '0;
      sh_blank_p0  <= '1;
`ifdef SEG7_SCAN_DIM_EN
      dim_cnt_p0   <= '0;
`endif
      an_p1        <= AN_OFF;
      seg_p1       <= SEG_OFF;
      tick_p1      <= 1'b0;
    end else begin
      cnt_p0       <= cnt_nxt;
      idx_p0       <= idx_nxt;
      sh_digits_p0 <= digits_nxt;
      sh_dp_p0     <= dp_nxt;
      sh_blank_p0  <= blank_nxt;
`ifdef SEG7_SCAN_DIM_EN
      dim_cnt_p0   <= dim_nxt;
`endif
      an_p1        <= an_drive(an_ah);
      seg_p1       <= seg_drive(seg_ah);
      tick_p1      <= frame_end;
    end
  end

  assign bus.an_o         = an_p1;
  assign bus.seg_o        = seg_p1;
  assign bus.frame_tick_o = tick_p1;

endmodule
